// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM-backed memory stage.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StDone
  } mem_state_e;

  localparam logic [31:0] DefaultBaseAddr = 32'd1024;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned WaitCntW        = 3;

endpackage

// File: rtl/mem_stage_sram_wait_ctr.sv
// Loadable wait-state down-counter; last is high while the count sits at zero.
module sram_wait_ctr
  import mem_pkg::*;
#(
  parameter int unsigned Width = WaitCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic [Width-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/mem_stage_sram.sv
// Memory stage: 32-bit loads/stores as two 16-bit SRAM transfers with wait states.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned / out-of-range accesses and adds mem_fault.
module mem_stage_sram
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DefaultBaseAddr,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               WB_EN,
  input  logic               MEM_R,
  input  logic               MEM_W,
  input  logic [31:0]        ALU_res,
  input  logic [31:0]        Val_Rm,
  input  logic [3:0]         dest,
  output logic               WB_EN_out,
  output logic               MEM_R_out,
  output logic [31:0]        ALU_res_out,
  output logic [3:0]         dest_out,
  output logic [31:0]        data_mem,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic               mem_fault
`endif
);

  localparam logic [WaitCntW-1:0] WaitLoad = WaitCntW'(WAIT_CYCLES);

  mem_state_e          state_q;
  logic [SRAM_AW-2:0]  hw_q;
  logic                wr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         eff;
  logic [SRAM_AW-2:0]  hw_base;
  logic                req;
  logic                is_wr;
  logic                fault;
  logic                cnt_load;
  logic                cnt_last;
  logic [WaitCntW-1:0] cnt;
  logic                unused_eff;

  assign WB_EN_out   = WB_EN;
  assign MEM_R_out   = MEM_R;
  assign ALU_res_out = ALU_res;
  assign dest_out    = dest;

  assign eff        = ALU_res - BASE_ADDR;
  assign hw_base    = eff[SRAM_AW:2];
  assign unused_eff = ^{eff[31:SRAM_AW+1], eff[1:0]};
  assign req        = MEM_R | MEM_W;
  assign is_wr      = MEM_W & ~MEM_R;

`ifdef MEM_ALIGN_CHECK_EN
  assign fault = (ALU_res[1:0] != 2'b00) || ((eff >> (SRAM_AW + 1)) != 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_fault <= 1'b0;
    end else if (state_q == StIdle && req && fault) begin
      mem_fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

  assign cnt_load = (state_q == StIdle && req && !fault) || (state_q == StLo && cnt_last);

  sram_wait_ctr #(
    .Width (WaitCntW)
  ) u_wait_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WaitLoad),
    .count    (cnt),
    .last     (cnt_last)
  );

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StIdle:  ready = ~req;
      StDone:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // SRAM strobes are registered one cycle ahead: we_n rises for the last cycle of a
  // multi-cycle phase, so it is decided while the counter still reads 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      data_mem    <= '0;
      hw_q        <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (fault) begin
              state_q <= StDone;
              if (!is_wr) begin
                data_mem <= '0;
              end
            end else begin
              state_q     <= StLo;
              hw_q        <= hw_base;
              wr_q        <= is_wr;
              wdata_q     <= Val_Rm;
              sram_addr   <= {hw_base, 1'b0};
              sram_dq_out <= Val_Rm[15:0];
              sram_dq_oe  <= is_wr;
              sram_we_n   <= ~is_wr;
            end
          end
        end
        StLo: begin
          if (cnt_last) begin
            state_q     <= StHi;
            sram_addr   <= {hw_q, 1'b1};
            sram_dq_out <= wdata_q[31:16];
            sram_we_n   <= ~wr_q;
            if (!wr_q) begin
              data_mem[15:0] <= sram_dq_in;
            end
          end else begin
            sram_we_n <= ~wr_q | (cnt == WaitCntW'(1));
          end
        end
        StHi: begin
          if (cnt_last) begin
            state_q    <= StDone;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            if (!wr_q) begin
              data_mem[31:16] <= sram_dq_in;
            end
          end else begin
            sram_we_n <= ~wr_q | (cnt == WaitCntW'(1));
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed plus randomized bench for mem_stage_sram with a word-level memory model.
module tb_mem_stage_sram;

  localparam int unsigned TbWait = 1;
  localparam int unsigned TbAw   = 10;
  localparam int          AccLow = 1 + 2 * (TbWait + 1);
  localparam int          WrStb  = 2 * ((TbWait == 0) ? 1 : TbWait);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             WB_EN = 1'b0, MEM_R = 1'b0, MEM_W = 1'b0;
  logic [31:0]      ALU_res = '0, Val_Rm = '0;
  logic [3:0]       dest = '0;
  logic             WB_EN_out, MEM_R_out, ready, sram_dq_oe, sram_we_n;
  logic [31:0]      ALU_res_out, data_mem;
  logic [3:0]       dest_out;
  logic [TbAw-1:0]  sram_addr;
  logic [15:0]      sram_dq_out, sram_dq_in;
`ifdef MEM_ALIGN_CHECK_EN
  logic             mem_fault;
`endif

  int checks = 0;
  int failures = 0;

  logic [15:0] sram [0:(1<<TbAw)-1];
  logic [31:0] ref_word [0:15];
  logic [31:0] last_dm;

  always #5 clk = ~clk;

  always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
  assign sram_dq_in = sram[sram_addr];

  mem_stage_sram #(
    .BASE_ADDR   (32'd1024),
    .WAIT_CYCLES (TbWait),
    .SRAM_AW     (TbAw)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .WB_EN       (WB_EN),
    .MEM_R       (MEM_R),
    .MEM_W       (MEM_W),
    .ALU_res     (ALU_res),
    .Val_Rm      (Val_Rm),
    .dest        (dest),
    .WB_EN_out   (WB_EN_out),
    .MEM_R_out   (MEM_R_out),
    .ALU_res_out (ALU_res_out),
    .dest_out    (dest_out),
    .data_mem    (data_mem),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_we_n   (sram_we_n)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .mem_fault   (mem_fault)
`endif
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic nonmem(input logic [31:0] a);
    logic [3:0] d;
    d = 4'($urandom);
    @(posedge clk); #1;
    MEM_R = 1'b0; MEM_W = 1'b0; WB_EN = 1'b1; ALU_res = a; dest = d;
    #1;
    check("nonmem ready", ready, 1);
    check("nonmem wb_en pass", WB_EN_out, 1);
    check("nonmem mem_r pass", MEM_R_out, 0);
    check("nonmem alu pass", ALU_res_out, a);
    check("nonmem dest pass", dest_out, d);
    @(posedge clk); #2;
    check("nonmem we_n idle", sram_we_n, 1);
    check("nonmem oe idle", sram_dq_oe, 0);
  endtask

  // One access; the request is held until ready is seen high (the DONE cycle).
  task automatic access(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_dm, input int exp_low,
                        input int exp_stb);
    int low;
    int stb;
    @(posedge clk); #1;
    MEM_R = rd; MEM_W = wr; WB_EN = rd; ALU_res = addr; Val_Rm = wdata; dest = 4'($urandom);
    #1;
    check({tag, " alu pass"}, ALU_res_out, addr);
    low = 0;
    stb = 0;
    while (ready !== 1'b1 && low < 40) begin
      low++;
      if (sram_we_n === 1'b0) stb++;
      @(posedge clk); #2;
    end
    check({tag, " ready low cycles"}, low, exp_low);
    check({tag, " we_n strobes"}, stb, exp_stb);
    check({tag, " data_mem"}, data_mem, exp_dm);
  endtask

  initial begin
    int op;
    int idx;
    logic [31:0] v;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset ready", ready, 1);
    check("reset data_mem", data_mem, 0);
    check("reset sram_addr", sram_addr, 0);
    check("reset dq_out", sram_dq_out, 0);
    check("reset oe", sram_dq_oe, 0);
    check("reset we_n", sram_we_n, 1);
`ifdef MEM_ALIGN_CHECK_EN
    check("reset mem_fault", mem_fault, 0);
`endif
    last_dm = 32'h0;

    nonmem(32'h55);

    access("store deadbeef", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, last_dm, AccLow, WrStb);
    check("sram hw0", sram[0], 16'hBEEF);
    check("sram hw1", sram[1], 16'hDEAD);
    access("store 1028", 1'b0, 1'b1, 32'd1028, 32'h12345678, last_dm, AccLow, WrStb);
    access("load 1024", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, AccLow, 0);
    // Back-to-back: the store is presented the cycle after the load's DONE.
    access("b2b load 1028", 1'b1, 1'b0, 32'd1028, 32'h0, 32'h12345678, AccLow, 0);
    last_dm = 32'h12345678;
    access("b2b store 1032", 1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, last_dm, AccLow, WrStb);
    check("sram hw4", sram[4], 16'hF00D);
    check("sram hw5", sram[5], 16'hCAFE);

    // Reset during the HI phase of a store.
    @(posedge clk); #1;
    MEM_R = 1'b0; MEM_W = 1'b1; ALU_res = 32'd1024 + 32'd400; Val_Rm = 32'hA5A55A5A;
    repeat (3) @(posedge clk);
    #2;
    check("hi phase strobe", sram_we_n, 0);
    rst = 1'b1;
    #1;
    check("rst we_n", sram_we_n, 1);
    check("rst oe", sram_dq_oe, 0);
    check("rst data_mem", data_mem, 0);
    MEM_W = 1'b0;
    #1;
    check("rst idle ready", ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst sram_addr", sram_addr, 0);
    last_dm = 32'h0;

    // Randomized phase against the word-level model.
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_word[i] = v;
      access("rand init store", 1'b0, 1'b1, 32'd1024 + 32'(4 * i), v, last_dm, AccLow, WrStb);
    end
    for (int i = 0; i < 24; i++) begin
      op  = int'($urandom_range(0, 3));
      idx = int'($urandom_range(0, 15));
      if (op == 0) begin
        nonmem($urandom);
      end else if (op == 2) begin
        v = $urandom;
        ref_word[idx] = v;
        access("rand store", 1'b0, 1'b1, 32'd1024 + 32'(4 * idx), v, last_dm, AccLow, WrStb);
      end else begin
        // op 3 raises both MEM_R and MEM_W: the load must win.
        last_dm = ref_word[idx];
        access("rand load", 1'b1, op == 3, 32'd1024 + 32'(4 * idx), $urandom, last_dm,
               AccLow, 0);
      end
    end

`ifdef MEM_ALIGN_CHECK_EN
    check("pre fault mem_fault", mem_fault, 0);
    access("misaligned load", 1'b1, 1'b0, 32'd1026, 32'h0, 32'h0, 1, 0);
    check("fault set", mem_fault, 1);
    last_dm = 32'h0;
    nonmem(32'h77);
    check("fault sticky", mem_fault, 1);
    access("range store", 1'b0, 1'b1, 32'd1024 + (32'd1 << (TbAw + 1)), 32'h1, last_dm, 1, 0);
    check("fault still set", mem_fault, 1);
`endif

    @(posedge clk); #1;
    MEM_R = 1'b0; MEM_W = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
